// File: rtl/operand_issue.sv
// RV32I decode / operand-issue stage in front of the ALU.
// Decodes OP, OP-IMM, LUI and AUIPC into one registered entry with a valid/ready handshake.
module operand_issue #(
  parameter bit WB_BYPASS    = 1'b1,
  parameter bit REFRESH_HELD = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        wb_we_i,
  input  logic [4:0]  wb_rd_i,
  input  logic [31:0] wb_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] operand_1_o,
  output logic [31:0] operand_2_o,
  output logic [6:0]  funct7_o,
  output logic [2:0]  funct3_o,
  output logic [4:0]  rd_o,
  output logic        rd_we_o,
  output logic        illegal_o
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_NORMAL  = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [2:0] F3_ADD     = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL     = 3'b101;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e state_q, state_d;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_u;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign rd     = instr_i[11:7];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {instr_i[31:12], 12'b0};

  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  // Index 0 is rs1 / operand_1, index 1 is rs2 / operand_2.
  logic [4:0]  rs_addr [2];
  logic [31:0] rs_data [2];
  logic [31:0] rs_val  [2];

  assign rs_addr[0] = rs1_addr_o;
  assign rs_addr[1] = rs2_addr_o;
  assign rs_data[0] = rs1_data_i;
  assign rs_data[1] = rs2_data_i;

  // Held-entry bookkeeping used to refresh operands from later writebacks
  logic [4:0]  held_addr_q [2];
  logic [1:0]  held_src_q;
  logic [1:0]  refresh_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign rs_val[gi] = (rs_addr[gi] == 5'd0) ? 32'd0 :
                          (WB_BYPASS && wb_we_i && (wb_rd_i == rs_addr[gi])) ? wb_data_i :
                          rs_data[gi];

      assign refresh_hit[gi] = REFRESH_HELD && held_src_q[gi] && wb_we_i &&
                               (wb_rd_i != 5'd0) && (wb_rd_i == held_addr_q[gi]);
    end
  endgenerate

  // Decode of the instruction currently presented at the input
  logic [31:0] dec_op1;
  logic [31:0] dec_op2;
  logic [6:0]  dec_f7;
  logic [2:0]  dec_f3;
  logic        dec_legal;
  logic [1:0]  dec_src;
  logic        dec_rd_we;

  always_comb begin
    dec_op1   = 32'd0;
    dec_op2   = 32'd0;
    dec_f7    = F7_NORMAL;
    dec_f3    = F3_ADD;
    dec_legal = 1'b0;
    dec_src   = 2'b00;

    unique case (opcode)
      OPC_OP: begin
        dec_legal = (f7 == F7_NORMAL) ||
                    ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SRL)));
        if (dec_legal) begin
          dec_op1 = rs_val[0];
          dec_op2 = rs_val[1];
          dec_f7  = f7;
          dec_f3  = f3;
          dec_src = 2'b11;
        end
      end

      OPC_OP_IMM: begin
        // Only shifts carry a funct7 field; ADDI with imm[11:5]=0100000 is still an add.
        unique case (f3)
          F3_SLL:  dec_legal = (f7 == F7_NORMAL);
          F3_SRL:  dec_legal = (f7 == F7_NORMAL) || (f7 == F7_ALT);
          default: dec_legal = 1'b1;
        endcase
        if (dec_legal) begin
          dec_op1 = rs_val[0];
          dec_op2 = imm_i;
          dec_f3  = f3;
          dec_f7  = ((f3 == F3_SRL) && (f7 == F7_ALT)) ? F7_ALT : F7_NORMAL;
          dec_src = 2'b01;
        end
      end

      OPC_LUI: begin
        dec_legal = 1'b1;
        dec_op2   = imm_u;
      end

      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec_op1   = pc_i;
        dec_op2   = imm_u;
      end

      default: begin
        dec_legal = 1'b0;
      end
    endcase
  end

  assign dec_rd_we = dec_legal && (rd != 5'd0);

  // Handshake and state control
  logic accept;
  logic consume;
  logic load_en;
  logic refresh_en;

  assign in_ready_o  = rst_ni && !flush_i && ((state_q == ST_EMPTY) || out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign consume     = (state_q == ST_FULL) && out_ready_i;
  assign out_valid_o = (state_q == ST_FULL);

  always_comb begin
    state_d    = state_q;
    load_en    = 1'b0;
    refresh_en = 1'b0;

    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_FULL;
      load_en = 1'b1;
    end else if (consume) begin
      state_d = ST_EMPTY;
    end else if (state_q == ST_FULL) begin
      refresh_en = 1'b1;
    end
  end

  // Output entry registers
  logic [31:0] operand_1_q;
  logic [31:0] operand_2_q;
  logic [6:0]  funct7_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        rd_we_q;
  logic        illegal_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= ST_EMPTY;
      operand_1_q    <= 32'd0;
      operand_2_q    <= 32'd0;
      funct7_q       <= F7_NORMAL;
      funct3_q       <= F3_ADD;
      rd_q           <= 5'd0;
      rd_we_q        <= 1'b0;
      illegal_q      <= 1'b0;
      held_addr_q[0] <= 5'd0;
      held_addr_q[1] <= 5'd0;
      held_src_q     <= 2'b00;
    end else begin
      state_q <= state_d;
      if (load_en) begin
        operand_1_q    <= dec_op1;
        operand_2_q    <= dec_op2;
        funct7_q       <= dec_f7;
        funct3_q       <= dec_f3;
        rd_q           <= rd;
        rd_we_q        <= dec_rd_we;
        illegal_q      <= !dec_legal;
        held_addr_q[0] <= rs_addr[0];
        held_addr_q[1] <= rs_addr[1];
        held_src_q     <= dec_src;
      end else if (refresh_en) begin
        // A stalled entry must not go stale against registers written meanwhile.
        if (refresh_hit[0]) begin
          operand_1_q <= wb_data_i;
        end
        if (refresh_hit[1]) begin
          operand_2_q <= wb_data_i;
        end
      end
    end
  end

  assign operand_1_o = operand_1_q;
  assign operand_2_o = operand_2_q;
  assign funct7_o    = funct7_q;
  assign funct3_o    = funct3_q;
  assign rd_o        = rd_q;
  assign rd_we_o     = rd_we_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: per-cycle compare against a behavioural model,
// plus directed vectors with hand-computed expectations.
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] operand_1, operand_2;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        rd_we, illegal;

  logic [31:0] rf [32];
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  operand_issue dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc),
    .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .operand_1_o(operand_1), .operand_2_o(operand_2),
    .funct7_o(funct7), .funct3_o(funct3),
    .rd_o(rd), .rd_we_o(rd_we), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_cons = 0;
  int mdl_cons = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        r1;
    logic        r2;
  } ent_t;

  logic m_valid = 1'b0;
  ent_t m_e = '0;

  function automatic logic [31:0] read_reg(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_rd == a) return wb_data;
    return rf[a];
  endfunction

  // What the ALU must receive for a given instruction, written mnemonic by mnemonic.
  function automatic ent_t golden(input logic [31:0] ins, input logic [31:0] pcv);
    ent_t e;
    logic [6:0] opc;
    logic [2:0] fn3;
    logic [6:0] fn7;
    logic       ok;
    e     = '0;
    opc   = ins[6:0];
    fn3   = ins[14:12];
    fn7   = ins[31:25];
    e.rd  = ins[11:7];
    e.a1  = ins[19:15];
    e.a2  = ins[24:20];
    ok    = 1'b0;
    if (opc == 7'h33) begin
      // ADD..AND with funct7 0; SUB and SRA are the only alternate forms
      ok = (fn7 == 7'h00) || (fn7 == 7'h20 && (fn3 == 3'd0 || fn3 == 3'd5));
      if (ok) begin
        e.op1 = read_reg(e.a1); e.op2 = read_reg(e.a2);
        e.f7 = fn7; e.f3 = fn3; e.r1 = 1'b1; e.r2 = 1'b1;
      end
    end else if (opc == 7'h13) begin
      if (fn3 == 3'd1)      ok = (fn7 == 7'h00);
      else if (fn3 == 3'd5) ok = (fn7 == 7'h00) || (fn7 == 7'h20);
      else                  ok = 1'b1;
      if (ok) begin
        e.op1 = read_reg(e.a1);
        e.op2 = 32'($signed(ins[31:20]));
        e.f3  = fn3;
        e.f7  = (fn3 == 3'd5) ? fn7 : 7'h00;
        e.r1  = 1'b1;
      end
    end else if (opc == 7'h37) begin
      ok = 1'b1; e.op2 = ins[31:12] << 12;
    end else if (opc == 7'h17) begin
      ok = 1'b1; e.op1 = pcv; e.op2 = ins[31:12] << 12;
    end
    e.ill = !ok;
    e.we  = ok && (e.rd != 5'd0);
    return e;
  endfunction

  always @(negedge rst_n) begin
    m_valid = 1'b0;
    m_e     = '0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready && !flush) dut_cons++;
      if (flush) begin
        m_valid = 1'b0;
      end else if (in_valid && (!m_valid || out_ready)) begin
        if (m_valid) begin
          mdl_cons++;
          $display("issue rd=%0d op1=%h op2=%h f7=%h f3=%0d ill=%0b", m_e.rd, m_e.op1, m_e.op2, m_e.f7, m_e.f3, m_e.ill);
        end
        m_e     = golden(instr, pc);
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        mdl_cons++;
        $display("issue rd=%0d op1=%h op2=%h f7=%h f3=%0d ill=%0b", m_e.rd, m_e.op1, m_e.op2, m_e.f7, m_e.f3, m_e.ill);
        m_valid = 1'b0;
      end else if (m_valid && wb_we && wb_rd != 5'd0) begin
        if (m_e.r1 && wb_rd == m_e.a1) m_e.op1 = wb_data;
        if (m_e.r2 && wb_rd == m_e.a2) m_e.op2 = wb_data;
      end
      if (wb_we && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(rst_n && !flush && (!m_valid || out_ready)));
    chk("rs1_addr", 32'(rs1_addr), 32'(instr[19:15]));
    chk("rs2_addr", 32'(rs2_addr), 32'(instr[24:20]));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || !rst_n) begin
      chk("operand_1", operand_1, m_e.op1);
      chk("operand_2", operand_2, m_e.op2);
      chk("funct7", 32'(funct7), 32'(m_e.f7));
      chk("funct3", 32'(funct3), 32'(m_e.f3));
      chk("rd", 32'(rd), 32'(m_e.rd));
      chk("rd_we", 32'(rd_we), 32'(m_e.we));
      chk("illegal", 32'(illegal), 32'(m_e.ill));
    end
  end

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                        input logic [2:0] f3, input logic [4:0] d);
    return {imm, s1, f3, d, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] d, input logic [6:0] opc);
    return {imm, d, opc};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tbl [12];
  int base;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[1] = 32'd7;
    rf[2] = 32'd9;
    rf[6] = 32'h8000_0010;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_operand_1", operand_1, 32'd0);
    chk("rst_funct7", 32'(funct7), 32'h00);
    chk("rst_rd_we", 32'(rd_we), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // SUB x3,x1,x2 -> 7, 9, ALT/ADD one cycle later
    in_valid = 1'b1; instr = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_op1", operand_1, 32'd7);
    chk("sub_op2", operand_2, 32'd9);
    chk("sub_f7", 32'(funct7), 32'h20);
    chk("sub_f3", 32'(funct3), 32'd0);
    chk("sub_rd", 32'(rd), 32'd3);
    chk("sub_we", 32'(rd_we), 32'd1);

    // SRAI x5,x6,31 back-to-back with ADDI x1,x0,-1
    tick;
    in_valid = 1'b1; instr = enc_i({7'h20, 5'd31}, 5'd6, 3'd5, 5'd5);
    tick;
    instr = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1);
    @(negedge clk);
    chk("srai_shamt", 32'(operand_2[4:0]), 32'd31);
    chk("srai_op1", operand_1, 32'h8000_0010);
    chk("srai_f7", 32'(funct7), 32'h20);
    chk("srai_f3", 32'(funct3), 32'd5);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk("addi_op1", operand_1, 32'd0);
    chk("addi_op2", operand_2, 32'hFFFF_FFFF);
    chk("addi_f7", 32'(funct7), 32'h00);
    chk("addi_f3", 32'(funct3), 32'd0);
    tick;

    // Bypass then refresh of a held entry: ADD x4,x1,x1
    in_valid = 1'b1; instr = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd4);
    out_ready = 1'b0; wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
    tick;
    in_valid = 1'b0; wb_data = 32'h66;
    @(negedge clk);
    chk("byp_op1", operand_1, 32'h55);
    chk("byp_op2", operand_2, 32'h55);
    tick;
    wb_we = 1'b0;
    @(negedge clk);
    chk("hold_op1", operand_1, 32'h66);
    chk("hold_op2", operand_2, 32'h66);
    out_ready = 1'b1;
    tick;

    // Backpressure: three instructions, two stall cycles
    base = dut_cons;
    in_valid = 1'b1; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd7);
    tick;
    instr = enc_r(7'h00, 5'd1, 5'd2, 3'd4, 5'd8); out_ready = 1'b0;
    @(negedge clk);
    chk("bp_rd_a", 32'(rd), 32'd7);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    tick;
    @(negedge clk);
    chk("bp_rd_held", 32'(rd), 32'd7);
    chk("bp_op1_held", operand_1, 32'h66);
    tick;
    out_ready = 1'b1;
    tick;
    instr = enc_i(12'h0F0, 5'd2, 3'd6, 5'd9);
    @(negedge clk);
    chk("bp_rd_b", 32'(rd), 32'd8);
    chk("bp_f3_b", 32'(funct3), 32'd4);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_rd_c", 32'(rd), 32'd9);
    chk("bp_op2_c", operand_2, 32'h0F0);
    tick;
    chk("bp_count", 32'(dut_cons - base), 32'd3);

    // Flush with an input offered, then flush of a held entry
    flush = 1'b1; in_valid = 1'b1; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd10);
    tick;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_in_drop", 32'(out_valid), 32'd0);
    tick;
    in_valid = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_held", 32'(out_valid), 32'd0);

    // Illegal encodings
    tick;
    in_valid = 1'b1; instr = 32'h0000_007F;
    tick;
    instr = enc_r(7'h20, 5'd2, 5'd1, 3'd7, 5'd11);
    @(negedge clk);
    chk("ill7f_illegal", 32'(illegal), 32'd1);
    chk("ill7f_we", 32'(rd_we), 32'd0);
    tick;
    instr = enc_u(20'hABCDE, 5'd12, 7'b0010111); pc = 32'h0000_1000;
    @(negedge clk);
    chk("illand_illegal", 32'(illegal), 32'd1);
    chk("illand_valid", 32'(out_valid), 32'd1);
    chk("illand_op1", operand_1, 32'd0);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    chk("auipc_op1", operand_1, 32'h0000_1000);
    chk("auipc_op2", operand_2, 32'hABCD_E000);

    // Mixed traffic: random fields, writebacks, backpressure and flushes
    tbl[0]  = enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd0);
    tbl[1]  = enc_r(7'h20, 5'd0, 5'd0, 3'd0, 5'd0);
    tbl[2]  = enc_r(7'h20, 5'd0, 5'd0, 3'd5, 5'd0);
    tbl[3]  = enc_r(7'h20, 5'd0, 5'd0, 3'd1, 5'd0);
    tbl[4]  = enc_i(12'h800, 5'd0, 3'd0, 5'd0);
    tbl[5]  = enc_i(12'h41F, 5'd0, 3'd5, 5'd0);
    tbl[6]  = enc_i(12'h41F, 5'd0, 3'd1, 5'd0);
    tbl[7]  = enc_i(12'h01F, 5'd0, 3'd1, 5'd0);
    tbl[8]  = enc_u(20'h12345, 5'd0, 7'b0110111);
    tbl[9]  = enc_u(20'hFFFFF, 5'd0, 7'b0010111);
    tbl[10] = 32'h0000_0073;
    tbl[11] = enc_r(7'h01, 5'd0, 5'd0, 3'd0, 5'd0);
    for (int i = 0; i < 60; i++) begin
      tick;
      instr = tbl[$urandom_range(0, 11)];
      instr[11:7] = 5'($urandom_range(0, 7));
      instr[24:15] = 10'($urandom_range(0, 1023)) & 10'b00111_00111;
      pc        = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 9) == 0);
      wb_we     = ($urandom_range(0, 1) != 0);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
    end
    tick;
    in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; out_ready = 1'b1;
    repeat (2) tick;
    chk("consume_count", 32'(dut_cons), 32'(mdl_cons));

    // Reset while FULL
    in_valid = 1'b1; out_ready = 1'b0; instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd4);
    tick;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstfull_valid", 32'(out_valid), 32'd0);
    chk("rstfull_op1", operand_1, 32'd0);
    chk("rstfull_rd", 32'(rd), 32'd0);
    chk("rstfull_ready", 32'(in_ready), 32'd0);
    repeat (2) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
